// File: rtl/rc_column_mem_port.sv
// rc_column_mem_port: one memory bus port shared by the N_RC cells of a column.
// A batch of requests is captured in IDLE and then served one bus transaction
// at a time in round-robin order. Every served cell gets a one-cycle
// completion pulse. Load data is broadcast to all cells on rc_rdata_o.
module rc_column_mem_port #(
  parameter int N_RC     = 4,
  parameter int DP_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_RC-1:0]          rc_req_i,
  input  logic [N_RC-1:0]          rc_wen_i,
  input  logic [N_RC*DP_WIDTH-1:0] rc_add_i,
  input  logic [N_RC*DP_WIDTH-1:0] rc_wdata_i,
  output logic [DP_WIDTH-1:0]      rc_rdata_o,
  output logic [N_RC-1:0]          rc_rvalid_o,
  output logic                     col_busy_o,
  output logic                     mem_req_o,
  input  logic                     mem_gnt_i,
  output logic                     mem_we_o,
  output logic [DP_WIDTH-1:0]      mem_addr_o,
  output logic [DP_WIDTH-1:0]      mem_wdata_o,
  input  logic                     mem_rvalid_i,
  input  logic [DP_WIDTH-1:0]      mem_rdata_i
);

  localparam int IDX_W = (N_RC > 1) ? $clog2(N_RC) : 1;
  localparam logic [N_RC-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e                          state_q;
  logic [N_RC-1:0]                 pend_q;
  logic [IDX_W-1:0]                rr_ptr_q;
  logic [IDX_W-1:0]                sel_q;
  logic [N_RC-1:0]                 we_q;
  logic [N_RC-1:0][DP_WIDTH-1:0]   add_q;
  logic [N_RC-1:0][DP_WIDTH-1:0]   wdata_q;
  logic                            mem_req_q;
  logic                            mem_we_q;
  logic [DP_WIDTH-1:0]             mem_addr_q;
  logic [DP_WIDTH-1:0]             mem_wdata_q;
  logic [N_RC-1:0]                 rc_rvalid_q;
  logic [DP_WIDTH-1:0]             rc_rdata_q;
  logic                            col_busy_q;

  logic [N_RC-1:0][DP_WIDTH-1:0]   add_in;
  logic [N_RC-1:0][DP_WIDTH-1:0]   wdata_in;
  logic [IDX_W-1:0]                sel_new_d;
  logic [IDX_W-1:0]                sel_nxt_d;
  logic [N_RC-1:0]                 pend_rem_d;
  logic [IDX_W-1:0]                rr_ptr_d;

  // Flat per-RC buses viewed as arrays; RC k sits at bits [k*DP_WIDTH +: DP_WIDTH].
  assign add_in   = rc_add_i;
  assign wdata_in = rc_wdata_i;

  // First set bit of vec, searching upward from start and wrapping modulo N_RC.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_RC-1:0]  vec,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = start;
    found   = 1'b0;
    for (int i = 0; i < N_RC; i++) begin
      idx = IDX_W'((int'(start) + i) % N_RC);
      if (!found && vec[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Next selection for a fresh batch and for the remainder of the current one.
  always_comb begin
    sel_new_d  = rr_pick(rc_req_i, rr_ptr_q);
    pend_rem_d = pend_q & ~(ONE << sel_q);
    sel_nxt_d  = rr_pick(pend_rem_d, rr_ptr_q);
    rr_ptr_d   = (rr_ptr_q == IDX_W'(N_RC - 1)) ? '0 : rr_ptr_q + 1'b1;
  end

  // Capture every cell's command at batch start; later input changes are ignored.
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && |rc_req_i) begin
      we_q    <= rc_wen_i;
      add_q   <= add_in;
      wdata_q <= wdata_in;
    end
  end

  // Batch controller with registered bus and cell-side outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rc_rvalid_q <= '0;
      rc_rdata_q  <= '0;
      col_busy_q  <= 1'b0;
    end else begin
      rc_rvalid_q <= '0;
      case (state_q)
        IDLE: begin
          if (|rc_req_i) begin
            pend_q      <= rc_req_i;
            rr_ptr_q    <= rr_ptr_d;
            sel_q       <= sel_new_d;
            mem_req_q   <= 1'b1;
            mem_we_q    <= rc_wen_i[sel_new_d];
            mem_addr_q  <= add_in[sel_new_d];
            mem_wdata_q <= wdata_in[sel_new_d];
            col_busy_q  <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          // Command is held unchanged until the grant is seen.
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            rc_rvalid_q <= ONE << sel_q;
            pend_q      <= pend_rem_d;
            if (!we_q[sel_q]) begin
              rc_rdata_q <= mem_rdata_i;
            end
            if (|pend_rem_d) begin
              // Next command goes out in the same cycle as this completion pulse.
              sel_q       <= sel_nxt_d;
              mem_req_q   <= 1'b1;
              mem_we_q    <= we_q[sel_nxt_d];
              mem_addr_q  <= add_q[sel_nxt_d];
              mem_wdata_q <= wdata_q[sel_nxt_d];
              state_q     <= ISSUE;
            end else begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          // One dead cycle so a request still held after its pulse is not re-taken.
          col_busy_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rc_rvalid_o = rc_rvalid_q;
  assign rc_rdata_o  = rc_rdata_q;
  assign col_busy_o  = col_busy_q;

endmodule

// File: tb/tb_rc_column_mem_port.sv
// Bench for rc_column_mem_port: bus responder, batch-level scoreboard and
// directed scenarios with literal expectations.
module tb_rc_column_mem_port;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic [3:0]   rc_req_i = '0;
  logic [3:0]   rc_wen_i = '0;
  logic [127:0] rc_add_i = '0;
  logic [127:0] rc_wdata_i = '0;
  logic [31:0]  rc_rdata_o;
  logic [3:0]   rc_rvalid_o;
  logic         col_busy_o;
  logic         mem_req_o;
  logic         mem_gnt_i = 1'b0;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [31:0]  mem_wdata_o;
  logic         mem_rvalid_i = 1'b0;
  logic [31:0]  mem_rdata_i = '0;

  rc_column_mem_port #(.N_RC(4), .DP_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rc_req_i(rc_req_i), .rc_wen_i(rc_wen_i), .rc_add_i(rc_add_i), .rc_wdata_i(rc_wdata_i),
    .rc_rdata_o(rc_rdata_o), .rc_rvalid_o(rc_rvalid_o), .col_busy_o(col_busy_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } bus_t;
  typedef struct { int rc; logic ld; logic [31:0] addr; } pulse_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard state
  bus_t        exp_bus[$];
  pulse_t      exp_pulse[$];
  int          mrr = 0;
  logic [31:0] m_rdata = '0;

  // Responder / observation state
  logic        resp_en = 1'b1;
  int          stall_cnt = 0;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] log_addr[$];
  logic        log_we[$];
  logic [31:0] log_wd[$];
  int          req_run = 0;
  int          last_req_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents seen by the column
  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (a == 32'h100) return 32'hCAFE0001;
    return {16'hBEEF, a[15:0]};
  endfunction

  // Expected service of one batch: round-robin from the batch pointer.
  task automatic model_batch(input logic [3:0] req, input logic [3:0] wen,
                             input logic [127:0] add, input logic [127:0] wd);
    int k;
    bus_t b;
    pulse_t p;
    for (int i = 0; i < 4; i++) begin
      k = (mrr + i) % 4;
      if (req[k]) begin
        b.we = wen[k]; b.addr = add[k*32 +: 32]; b.wdata = wd[k*32 +: 32];
        exp_bus.push_back(b);
        p.rc = k; p.ld = !wen[k]; p.addr = add[k*32 +: 32];
        exp_pulse.push_back(p);
      end
    end
    mrr = (mrr + 1) % 4;
  endtask

  // Bus slave: optional grant stall, grant, then response in the following cycle.
  always @(negedge clk_i) begin
    bus_t eb;
    if (resp_en) begin
      mem_rvalid_i = 1'b0;
      if (mem_gnt_i) begin
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = cap_we ? ~rd_val(cap_addr) : rd_val(cap_addr);
      end else if (mem_req_o) begin
        if (stall_cnt > 0) begin
          stall_cnt--;
        end else begin
          mem_gnt_i = 1'b1;
          cap_we    = mem_we_o;
          cap_addr  = mem_addr_o;
          log_addr.push_back(mem_addr_o);
          log_we.push_back(mem_we_o);
          log_wd.push_back(mem_wdata_o);
          if (exp_bus.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_bus: got addr %h expected no transaction", mem_addr_o);
          end else begin
            eb = exp_bus.pop_front();
            chk("bus_we", 32'(mem_we_o), 32'(eb.we));
            chk("bus_addr", mem_addr_o, eb.addr);
            chk("bus_wdata", mem_wdata_o, eb.wdata);
          end
        end
      end
    end
  end

  // Per-cycle output check against the scoreboard.
  always begin
    logic        rs, gs, p_req, p_we;
    logic [31:0] p_addr, p_wd;
    pulse_t      ep;
    @(posedge clk_i);
    rs = rst_ni;
    gs = mem_gnt_i;
    #1;
    if (!rs) begin
      exp_bus.delete(); exp_pulse.delete();
      mrr = 0; m_rdata = '0; req_run = 0;
      chk("rst_req", 32'(mem_req_o), 0);
      chk("rst_we", 32'(mem_we_o), 0);
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_wdata", mem_wdata_o, 0);
      chk("rst_rvalid", 32'(rc_rvalid_o), 0);
      chk("rst_rdata", rc_rdata_o, 0);
      chk("rst_busy", 32'(col_busy_o), 0);
    end else begin
      if (rc_rvalid_o != 0) begin
        if (exp_pulse.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_pulse: got %b expected 0000", rc_rvalid_o);
        end else begin
          ep = exp_pulse.pop_front();
          chk("pulse_rc", 32'(rc_rvalid_o), 32'(1) << ep.rc);
          if (ep.ld) m_rdata = rd_val(ep.addr);
          chk("pulse_busy", 32'(col_busy_o), 1);
          chk("b2b_req", 32'(mem_req_o), 32'(exp_bus.size() > 0));
        end
      end
      chk("rdata_hold", rc_rdata_o, m_rdata);
      if (mem_req_o && p_req && !gs) begin
        chk("stable_we", 32'(mem_we_o), 32'(p_we));
        chk("stable_addr", mem_addr_o, p_addr);
        chk("stable_wdata", mem_wdata_o, p_wd);
      end
    end
    if (mem_req_o) req_run++;
    else if (req_run > 0) begin last_req_run = req_run; req_run = 0; end
    p_req = mem_req_o; p_we = mem_we_o; p_addr = mem_addr_o; p_wd = mem_wdata_o;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    rc_req_i = '0;
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic clear_log();
    log_addr.delete(); log_we.delete(); log_wd.delete();
  endtask

  // Present a batch, drop each cell's request after its pulse, wait for idle.
  task automatic run_batch(input logic [3:0] req, input logic [3:0] wen,
                           input logic [127:0] add, input logic [127:0] wd,
                           input int stall, input int hold, output int pulses);
    logic [3:0] left;
    int cyc;
    stall_cnt = stall;
    rc_req_i = req; rc_wen_i = wen; rc_add_i = add; rc_wdata_i = wd;
    model_batch(req, wen, add, wd);
    left = req; cyc = 0; pulses = 0;
    tick();
    rc_add_i = ~add; rc_wdata_i = ~wd; rc_wen_i = ~wen;
    while (left != 0 && cyc < 200) begin
      if (rc_rvalid_o != 0) pulses++;
      left &= ~rc_rvalid_o;
      rc_req_i = left;
      if (left != 0) begin tick(); cyc++; end
    end
    if (left != 0) begin
      n_tests++; n_fail++;
      $display("FAIL batch_timeout: got pending %b expected 0000", left);
    end
    if (hold > 0) begin
      rc_req_i = req;
      tick();
      rc_req_i = '0;
    end
    cyc = 0;
    while (col_busy_o && cyc < 20) begin tick(); cyc++; end
    chk("batch_idle", 32'(col_busy_o), 0);
    repeat (3) tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int np;
    // Reset state
    rst_ni = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
    chk("init_req", 32'(mem_req_o), 0);
    chk("init_busy", 32'(col_busy_o), 0);
    chk("init_rdata", rc_rdata_o, 0);

    // Single load from RC2, minimum latency
    clear_log();
    rc_req_i = 4'b0100; rc_wen_i = '0;
    rc_add_i = {32'h0, 32'h100, 32'h0, 32'h0}; rc_wdata_i = '0;
    model_batch(rc_req_i, rc_wen_i, rc_add_i, rc_wdata_i);
    tick();
    chk("t1_req", 32'(mem_req_o), 1);
    chk("t1_addr", mem_addr_o, 32'h100);
    chk("t1_we", 32'(mem_we_o), 0);
    chk("t1_busy", 32'(col_busy_o), 1);
    tick();
    chk("t2_req", 32'(mem_req_o), 0);
    chk("t2_rvalid", 32'(rc_rvalid_o), 0);
    tick();
    chk("t3_rvalid", 32'(rc_rvalid_o), 32'b0100);
    chk("t3_rdata", rc_rdata_o, 32'hCAFE0001);
    rc_req_i = '0;
    tick();
    chk("t4_busy", 32'(col_busy_o), 0);
    chk("t4_rvalid", 32'(rc_rvalid_o), 0);
    chk("t1_req_len", 32'(last_req_run), 1);
    repeat (2) tick();

    // Full batches: round-robin pointer advances per batch
    do_reset();
    clear_log();
    run_batch(4'hF, 4'h0, {32'h100C, 32'h1008, 32'h1004, 32'h1000}, '0, 0, 0, np);
    chk("rr1_n", 32'(log_addr.size()), 4);
    chk("rr1_0", log_addr[0], 32'h1000);
    chk("rr1_1", log_addr[1], 32'h1004);
    chk("rr1_2", log_addr[2], 32'h1008);
    chk("rr1_3", log_addr[3], 32'h100C);
    chk("rr1_pulses", 32'(np), 4);
    clear_log();
    run_batch(4'hF, 4'h0, {32'h100C, 32'h1008, 32'h1004, 32'h1000}, '0, 0, 0, np);
    chk("rr2_n", 32'(log_addr.size()), 4);
    chk("rr2_0", log_addr[0], 32'h1004);
    chk("rr2_1", log_addr[1], 32'h1008);
    chk("rr2_2", log_addr[2], 32'h100C);
    chk("rr2_3", log_addr[3], 32'h1000);
    chk("rr2_rdata", rc_rdata_o, 32'hBEEF1000);

    // Store with a five-cycle grant stall
    clear_log();
    run_batch(4'b0010, 4'b0010, {32'h0, 32'h0, 32'h40, 32'h0},
              {32'h0, 32'h0, 32'h55, 32'h0}, 5, 0, np);
    chk("stall_req_len", 32'(last_req_run), 6);
    chk("stall_pulses", 32'(np), 1);
    chk("stall_we", 32'(log_we[0]), 1);
    chk("stall_addr", log_addr[0], 32'h40);
    chk("stall_wdata", log_wd[0], 32'h55);
    chk("stall_rdata", rc_rdata_o, 32'hBEEF1000);

    // Reset while waiting for the response, then a late response
    resp_en = 1'b0;
    rc_req_i = 4'b0001; rc_wen_i = '0; rc_add_i = {96'h0, 32'h200};
    tick();
    chk("rw_req", 32'(mem_req_o), 1);
    mem_gnt_i = 1'b1;
    tick();
    chk("rw_wait_req", 32'(mem_req_o), 0);
    mem_gnt_i = 1'b0;
    rst_ni = 1'b0;
    rc_req_i = '0;
    tick();
    rst_ni = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'hDEAD0000;
    tick();
    chk("rw_rvalid", 32'(rc_rvalid_o), 0);
    chk("rw_req2", 32'(mem_req_o), 0);
    chk("rw_busy", 32'(col_busy_o), 0);
    mem_rvalid_i = 1'b0;
    tick();
    chk("rw_rvalid2", 32'(rc_rvalid_o), 0);
    chk("rw_rdata", rc_rdata_o, 0);
    resp_en = 1'b1;
    tick();

    // Request held one cycle past its pulse
    clear_log();
    run_batch(4'b0001, 4'b0000, {96'h0, 32'h80}, '0, 0, 1, np);
    repeat (3) tick();
    chk("hold_txns", 32'(log_addr.size()), 1);
    chk("hold_pulses", 32'(np), 1);
    chk("hold_rdata", rc_rdata_o, 32'hBEEF0080);

    // Mixed batch: RC1 store, RC3 load
    clear_log();
    run_batch(4'b1010, 4'b0010, {32'h300, 32'h0, 32'h210, 32'h0},
              {32'h0, 32'h0, 32'h1234, 32'h0}, 0, 0, np);
    chk("mix_n", 32'(log_we.size()), 2);
    chk("mix_we0", 32'(log_we[0]), 1);
    chk("mix_we1", 32'(log_we[1]), 0);
    chk("mix_addr0", log_addr[0], 32'h210);
    chk("mix_wd0", log_wd[0], 32'h1234);
    chk("mix_pulses", 32'(np), 2);
    chk("mix_rdata", rc_rdata_o, 32'hBEEF0300);
    chk("mix_left", 32'(exp_pulse.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
